led_colour_sequencer: RTL and testbench

//  Parametrised successor to the dynamic LED colour stepper. It holds a registered colour code

---
 rtl/led_colour_sequencer.sv | 86 ++++++++
 tb/tb_led_colour_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_colour_sequencer.sv
// rtl/led_colour_sequencer.sv - colour code stepper with manual/auto stepping, direction, hold and checked load
module led_colour_sequencer #(
    parameter int WIDTH  = 3,
    parameter int FIRST  = 1,
    parameter int LAST   = 6,
    parameter int PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             mode,
    input  logic             dir,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] colour,
    output logic             wrap,
    output logic             load_err
);

    localparam int TW = $clog2(PERIOD) + 1;
    localparam logic [WIDTH-1:0] FIRST_C   = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] LAST_C    = WIDTH'(LAST);
    localparam logic [TW-1:0]    TICK_LAST = TW'(PERIOD - 1);

    generate
        if (FIRST >= LAST || LAST > ((1 << WIDTH) - 1) || PERIOD < 1) begin : g_bad_params
            $error("led_colour_sequencer: illegal FIRST/LAST/PERIOD combination");
        end
    endgenerate

    logic [TW-1:0] tick;
    logic          step;
    logic          in_range;
    logic          load_ok;

    always_comb begin
        step     = mode ? (tick == TICK_LAST) : button;
        in_range = (colour >= FIRST_C) && (colour <= LAST_C);
        load_ok  = (load_val >= FIRST_C) && (load_val <= LAST_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            colour   <= FIRST_C;
            tick     <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                tick <= '0;
                if (load_ok) begin
                    colour <= load_val;
                end else begin
                    colour   <= FIRST_C;
                    load_err <= 1'b1;
                end
            end else if (!hold) begin
                // manual mode parks the timer at 0 so a switch to auto waits a full period
                tick <= mode ? (step ? '0 : tick + TW'(1)) : '0;
                if (!in_range) begin
                    colour <= FIRST_C;
                end else if (step) begin
                    if (!dir) begin
                        if (colour == LAST_C) begin
                            colour <= FIRST_C;
                            wrap   <= 1'b1;
                        end else begin
                            colour <= colour + WIDTH'(1);
                        end
                    end else begin
                        if (colour == FIRST_C) begin
                            colour <= LAST_C;
                            wrap   <= 1'b1;
                        end else begin
                            colour <= colour - WIDTH'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_led_colour_sequencer.sv
// tb/tb_led_colour_sequencer.sv - directed and randomized checks of led_colour_sequencer against a ring model
module tb_led_colour_sequencer;

    localparam int WIDTH  = 3;
    localparam int FIRST  = 1;
    localparam int LAST   = 6;
    localparam int PERIOD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             button;
    logic             mode;
    logic             dir;
    logic             hold;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] colour;
    logic             wrap;
    logic             load_err;

    int n_cmp = 0;
    int n_err = 0;

    // reference state: position on a ring of legal colours plus a free-running period count
    int m_colour;
    int m_tick;
    int m_wrap;
    int m_err;

    led_colour_sequencer #(
        .WIDTH (WIDTH),
        .FIRST (FIRST),
        .LAST  (LAST),
        .PERIOD(PERIOD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .button  (button),
        .mode    (mode),
        .dir     (dir),
        .hold    (hold),
        .load    (load),
        .load_val(load_val),
        .colour  (colour),
        .wrap    (wrap),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_cycle();
        int n;
        int idx;
        int nidx;
        bit stp;
        n      = LAST - FIRST + 1;
        m_wrap = 0;
        m_err  = 0;
        if (rst) begin
            m_colour = FIRST;
            m_tick   = 0;
        end else if (load) begin
            m_tick = 0;
            if (int'(load_val) >= FIRST && int'(load_val) <= LAST) begin
                m_colour = int'(load_val);
            end else begin
                m_colour = FIRST;
                m_err    = 1;
            end
        end else if (!hold) begin
            if (mode) begin
                stp    = (m_tick == PERIOD - 1);
                m_tick = (m_tick + 1) % PERIOD;
            end else begin
                stp    = button;
                m_tick = 0;
            end
            if (stp) begin
                idx  = m_colour - FIRST;
                nidx = (idx + (dir ? n - 1 : 1)) % n;
                m_wrap   = dir ? int'(idx == 0) : int'(nidx == 0);
                m_colour = FIRST + nidx;
            end
        end
    endtask

    task automatic cycle();
        model_cycle();
        @(posedge clk);
        #1;
        check("colour", 32'(colour), 32'(m_colour));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("load_err", 32'(load_err), 32'(m_err));
    endtask

    task automatic set_inputs(input logic r, input logic b, input logic m, input logic d,
                              input logic h, input logic l, input logic [WIDTH-1:0] lv);
        rst = r; button = b; mode = m; dir = d; hold = h; load = l; load_val = lv;
    endtask

    initial begin
        int exp_up[6];
        exp_up = '{2, 3, 4, 5, 6, 1};
        set_inputs(1, 0, 0, 0, 0, 0, 0);
        m_colour = FIRST; m_tick = 0; m_wrap = 0; m_err = 0;

        // reset with random other inputs
        for (int i = 0; i < 2; i++) begin
            set_inputs(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 3'($urandom));
            cycle();
            check("rst_colour", 32'(colour), 32'd1);
            check("rst_wrap", 32'(wrap), 32'd0);
            check("rst_err", 32'(load_err), 32'd0);
        end

        // manual up through the wrap
        set_inputs(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("up_colour", 32'(colour), 32'(exp_up[i]));
            check("up_wrap", 32'(wrap), (i == 5) ? 32'd1 : 32'd0);
        end

        // manual down from FIRST wraps to LAST
        set_inputs(0, 1, 0, 1, 0, 0, 0);
        cycle();
        check("down_colour", 32'(colour), 32'd6);
        check("down_wrap", 32'(wrap), 32'd1);
        set_inputs(0, 0, 0, 1, 0, 0, 0);
        cycle();
        check("down_wrap_clear", 32'(wrap), 32'd0);

        // auto mode ignores the button; from colour 6 the 4th cycle wraps to 1
        for (int i = 0; i < 8; i++) begin
            set_inputs(0, 1'(i % 2), 1, 0, 0, 0, 0);
            cycle();
            if (i == 3) begin
                check("auto_step1", 32'(colour), 32'd1);
                check("auto_wrap", 32'(wrap), 32'd1);
            end
        end
        check("auto_step2", 32'(colour), 32'd2);

        // hold for 3 cycles at tick 2 delays the next step by 3 cycles
        set_inputs(0, 1, 1, 0, 0, 0, 0);
        cycle();
        cycle();
        set_inputs(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_colour", 32'(colour), 32'd2);
        end
        set_inputs(0, 1, 1, 0, 0, 0, 0);
        cycle();
        check("post_hold_wait", 32'(colour), 32'd2);
        cycle();
        check("post_hold_step", 32'(colour), 32'd3);

        // loads: in range, out of range, and load beating a button step
        set_inputs(0, 0, 0, 0, 0, 1, 3'd4);
        cycle();
        check("load4", 32'(colour), 32'd4);
        set_inputs(0, 0, 0, 0, 0, 1, 3'd7);
        cycle();
        check("load7_colour", 32'(colour), 32'd1);
        check("load7_err", 32'(load_err), 32'd1);
        set_inputs(0, 0, 0, 0, 0, 0, 3'd7);
        cycle();
        check("load_err_clear", 32'(load_err), 32'd0);
        set_inputs(0, 1, 0, 0, 0, 1, 3'd5);
        cycle();
        check("load_wins", 32'(colour), 32'd5);

        // reset in auto mode at tick 2; first step 4 cycles after release
        set_inputs(0, 0, 1, 0, 0, 0, 0);
        cycle();
        cycle();
        set_inputs(1, 0, 1, 0, 0, 0, 0);
        cycle();
        check("auto_rst", 32'(colour), 32'd1);
        set_inputs(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("auto_rst_wait", 32'(colour), 32'd1);
        end
        cycle();
        check("auto_rst_step", 32'(colour), 32'd2);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 7) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            button   = 1'($urandom);
            dir      = ($urandom_range(0, 3) == 0) ? ~dir : dir;
            load_val = 3'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
